// File: rtl/mul_sched_pkg.sv
// Shared types, widths and helpers for the multiply/popcount scheduler.
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    COUNT = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int A_W_DEF   = 24;
  localparam int PROD_W    = 48;
  localparam int RES_W_DEF = 32;
  localparam int ONES_W    = 6;
  localparam int CNT_W     = 16;

  function automatic logic [ONES_W-1:0] popcount32(input logic [31:0] v);
    logic [ONES_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + ONES_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/shift_add_mul24.sv
// Iterative shift-and-add multiplier, one multiplier bit per cycle.
// MUL_SCHED_EARLY_TERM_EN: finish once the remaining multiplier bits are all zero.
module shift_add_mul24
  import mul_sched_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int P_W = PROD_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [A_W-1:0] a1,
  input  logic [A_W-1:0] a2,
  output logic           done,
  output logic [P_W-1:0] product
);

  localparam int BC_W = $clog2(A_W + 1);

  logic [P_W-1:0]  a1_ext;
  logic [P_W-1:0]  acc;
  logic [A_W-1:0]  a2_sh;
  logic [BC_W-1:0] bitcnt;
  logic            running;

`ifdef MUL_SCHED_EARLY_TERM_EN
  assign done = running && (a2_sh == '0);
`else
  assign done = running && (bitcnt == BC_W'(A_W - 1));
`endif

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      a1_ext  <= '0;
      acc     <= '0;
      a2_sh   <= '0;
      bitcnt  <= '0;
      running <= 1'b0;
    end else if (start) begin
      a1_ext  <= P_W'(a1);
      a2_sh   <= a2;
      acc     <= '0;
      bitcnt  <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (a2_sh[0]) acc <= acc + (a1_ext << bitcnt);
      a2_sh  <= a2_sh >> 1;
      bitcnt <= bitcnt + BC_W'(1);
      if (done) running <= 1'b0;
    end
  end

  assign product = acc;

endmodule

// File: rtl/mul_sched_arbiter.sv
// Round-robin front end sharing one shift_add_mul24 between NUM_REQ requesters.
// MULT length depends on MUL_SCHED_EARLY_TERM_EN inside shift_add_mul24.
module mul_sched_arbiter
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int A_W     = A_W_DEF,
  parameter int RES_W   = RES_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a1,
  input  logic [NUM_REQ*A_W-1:0] req_a2,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [RES_W-1:0]       resp_result,
  output logic [ONES_W-1:0]      resp_ones,
  output logic                   resp_ovf,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int P_W   = 2 * A_W;

  state_t           state, state_nx;
  logic [IDX_W-1:0] rr_ptr, rr_nx, gnt_idx, pick_idx, cand;
  logic             pick_found, start, mul_done, hs;
  logic [A_W-1:0]   a1_sel, a2_sel;
  logic [P_W-1:0]   product;
  logic [RES_W-1:0] res_q;
  logic [ONES_W-1:0] ones_q;
  logic             ovf_q;
  logic [CNT_W-1:0] op_count_q;

  // NOTE: every signal gets a default before the loop/case so no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign rr_nx  = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  assign start  = (state == IDLE) && pick_found;
  assign hs     = (state == RESP) && resp_ready[gnt_idx];
  assign a1_sel = req_a1[pick_idx*A_W +: A_W];
  assign a2_sel = req_a2[pick_idx*A_W +: A_W];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_found) state_nx = MULT;
      MULT:    if (mul_done)   state_nx = COUNT;
      COUNT:                   state_nx = RESP;
      RESP:    if (hs)         state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      res_q      <= '0;
      ones_q     <= '0;
      ovf_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        gnt_idx <= pick_idx;
        rr_ptr  <= rr_nx;
      end
      if (state == COUNT) begin
        res_q  <= product[RES_W-1:0];
        ones_q <= popcount32(product[31:0]);
        ovf_q  <= |product[P_W-1:RES_W];
      end
      if (hs) op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  shift_add_mul24 #(
    .A_W (A_W),
    .P_W (P_W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a1      (a1_sel),
    .a2      (a2_sel),
    .done    (mul_done),
    .product (product)
  );

  // Response fields read as zero outside RESP so idle buses carry no stale data.
  assign req_ready   = start ? (NUM_REQ'(1) << pick_idx) : '0;
  assign resp_valid  = (state == RESP) ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign resp_result = (state == RESP) ? res_q  : '0;
  assign resp_ones   = (state == RESP) ? ones_q : '0;
  assign resp_ovf    = (state == RESP) ? ovf_q  : 1'b0;
  assign busy        = (state != IDLE);
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_mul_sched_arbiter.sv
// Self-checking bench for mul_sched_arbiter: directed scenarios plus random traffic
// against a product/round-robin reference model.
module tb_mul_sched_arbiter;

  localparam int NUM_REQ = 2;
  localparam int A_W     = 24;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [NUM_REQ*A_W-1:0] req_a1, req_a2;
  logic [31:0]            resp_result;
  logic [5:0]             resp_ones;
  logic                   resp_ovf, busy;
  logic [15:0]            op_count;

  mul_sched_arbiter #(
    .NUM_REQ (NUM_REQ),
    .A_W     (A_W),
    .RES_W   (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a1      (req_a1),
    .req_a2      (req_a2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_ones   (resp_ones),
    .resp_ovf    (resp_ovf),
    .busy        (busy),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  int n_vec, n_err, cyc, m_count, m_rr, budget;
  bit re;
  logic               rst;
  logic [NUM_REQ-1:0] pend, rsp_rdy;
  logic [A_W-1:0]     op_a1 [NUM_REQ];
  logic [A_W-1:0]     op_a2 [NUM_REQ];

  always @(posedge clk) cyc <= cyc + 1;

  // Requester hold rule: a pending, unaccepted request keeps valid and operands.
  logic [NUM_REQ-1:0]     held;
  logic [NUM_REQ*A_W-1:0] held_a1, held_a2;
  always @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (!reset && held[i])
        assert (req_valid[i] && req_a1[i*A_W +: A_W] == held_a1[i*A_W +: A_W]
                && req_a2[i*A_W +: A_W] == held_a2[i*A_W +: A_W])
          else $error("requester %0d broke the hold rule", i);
    held    <= reset ? '0 : (req_valid & ~req_ready);
    held_a1 <= req_a1;
    held_a2 <= req_a2;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    reset      = rst;
    req_valid  = pend;
    resp_ready = rsp_rdy;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a1[i*A_W +: A_W] = op_a1[i];
      req_a2[i*A_W +: A_W] = op_a2[i];
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive_inputs();
    #1;
  endtask

  task automatic apply();
    drive_inputs();
    #1;
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] p, input int rr);
    for (int k = 0; k < NUM_REQ; k++)
      if (p[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
    return 0;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  function automatic int exp_latency(input logic [A_W-1:0] a2);
    int msb;
    msb = -1;
    for (int b = 0; b < A_W; b++) if (a2[b]) msb = b;
`ifdef MUL_SCHED_EARLY_TERM_EN
    return (msb < 0) ? 3 : msb + 4;
`else
    return (msb >= -1) ? 26 : 0;
`endif
  endfunction

  function automatic logic [A_W-1:0] rnd24();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return A_W'(1) << $urandom_range(0, A_W - 1);
      default: return A_W'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    rst  = 1'b1;
    pend = '0;
    step();
    step();
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_fields", {resp_ovf, resp_ones, resp_result}, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    rst = 1'b0;
    step();
    m_count = 0;
    m_rr    = 0;
  endtask

  // Serves the request the model says wins next; starts and ends in IDLE.
  task automatic serve_one(input int delay, input bit reissue);
    int w, n, lat, e_lat, busy_grants;
    logic [47:0] p;
    logic [31:0] e_res;
    logic [5:0]  e_ones;
    logic        e_ovf;
    w = pick(pend, m_rr);
    n = 0;
    while (req_ready == '0 && n < 40) begin
      step();
      n++;
    end
    check("grant", req_ready, onehot(w));
    p      = {24'd0, op_a1[w]} * {24'd0, op_a2[w]};
    e_res  = p[31:0];
    e_ones = 6'($countones(p[31:0]));
    e_ovf  = (p[47:32] != 16'd0);
    e_lat  = exp_latency(op_a2[w]);
    pend[w]  = 1'b0;
    op_a1[w] = rnd24();
    op_a2[w] = rnd24();
    rsp_rdy    = NUM_REQ'($urandom);
    rsp_rdy[w] = (delay == 0);
    step();
    m_rr = (w + 1) % NUM_REQ;
    check("ready_pulse", req_ready, 0);
    check("busy_mult", busy, 1);
    lat = 1;
    busy_grants = 0;
    while (resp_valid == '0 && lat < 60) begin
      if (req_ready != '0) busy_grants++;
      step();
      lat++;
    end
    check("latency", lat, e_lat);
    check("no_grant_busy", busy_grants, 0);
    check("resp_valid", resp_valid, onehot(w));
    check("resp_result", resp_result, e_res);
    check("resp_ones", resp_ones, e_ones);
    check("resp_ovf", resp_ovf, e_ovf);
    for (int d = 0; d < delay; d++) begin
      step();
      check("hold_valid", resp_valid, onehot(w));
      check("hold_result", {resp_ovf, resp_ones, resp_result}, {e_ovf, e_ones, e_res});
      check("hold_busy", busy, 1);
      check("hold_no_grant", req_ready, 0);
    end
    rsp_rdy[w] = 1'b1;
    apply();
    m_count = (m_count + 1) % 65536;
    if (reissue) begin
      pend[w]  = 1'b1;
      op_a1[w] = rnd24();
      op_a2[w] = rnd24();
    end
    step();
    check("op_count", op_count, m_count);
    check("idle_busy", busy, 0);
    check("idle_valid", resp_valid, 0);
    check("idle_fields", {resp_ovf, resp_ones, resp_result}, 0);
    if (pend != '0) check("next_grant", req_ready, onehot(pick(pend, m_rr)));
  endtask

  task automatic mid_op_reset();
    int seen;
    pend     = '0;
    op_a1[0] = 24'h123456;
    op_a2[0] = 24'hFFFFFF;
    pend[0]  = 1'b1;
    apply();
    check("rst_test_grant", req_ready, onehot(0));
    pend[0] = 1'b0;
    repeat (12) step();
    check("rst_test_busy", busy, 1);
    rst = 1'b1;
    apply();
    step();
    check("abandon_busy", busy, 0);
    check("abandon_valid", resp_valid, 0);
    check("abandon_fields", {resp_ovf, resp_ones, resp_result}, 0);
    check("abandon_count", op_count, 0);
    rst     = 1'b0;
    m_count = 0;
    m_rr    = 0;
    seen    = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (resp_valid != '0 || busy) seen++;
    end
    check("abandon_no_resp", seen, 0);
    check("abandon_count_after", op_count, 0);
    op_a1[1] = 24'h00ABCD;
    op_a2[1] = 24'h000777;
    pend[1]  = 1'b1;
    apply();
    serve_one(1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    cyc     = 0;
    m_count = 0;
    m_rr    = 0;
    rst     = 1'b1;
    pend    = '0;
    rsp_rdy = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a1[i] = '0;
      op_a2[i] = '0;
    end
    drive_inputs();
    do_reset();

    // Small product, then the all-ones corner on requester 1.
    op_a1[0] = 24'h000003;
    op_a2[0] = 24'h000005;
    pend[0]  = 1'b1;
    apply();
    serve_one(0, 1'b0);
    op_a1[1] = 24'hFFFFFF;
    op_a2[1] = 24'hFFFFFF;
    pend[1]  = 1'b1;
    apply();
    serve_one(0, 1'b0);

    // Both requesters from reset, reissuing: grants alternate 0,1,0,1.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a1[i] = rnd24();
      op_a2[i] = rnd24();
    end
    pend = '1;
    apply();
    serve_one(0, 1'b1);
    serve_one(0, 1'b1);
    serve_one(0, 1'b0);
    serve_one(0, 1'b0);

    // Back-pressure on requester 0 with requester 1 waiting.
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a1[i] = rnd24();
      op_a2[i] = rnd24();
    end
    pend = '1;
    apply();
    serve_one(10, 1'b0);
    serve_one(0, 1'b0);

    mid_op_reset();

    // Counter wrap from 0xFFFF.
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    m_count = 16'hFFFF;
    step();
    check("preload_count", op_count, 16'hFFFF);
    op_a1[0] = 24'h000002;
    op_a2[0] = 24'h000001;
    pend[0]  = 1'b1;
    apply();
    serve_one(0, 1'b0);

    // Short multipliers (latency differs only with early termination).
    op_a1[1] = 24'h0000FF;
    op_a2[1] = 24'h000000;
    pend[1]  = 1'b1;
    apply();
    serve_one(0, 1'b0);

    for (int b = 0; b < 14; b++) begin
      budget = 2;
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          op_a1[i] = rnd24();
          op_a2[i] = rnd24();
        end
      if (pend == '0) begin
        pend[0]  = 1'b1;
        op_a1[0] = rnd24();
        op_a2[0] = rnd24();
      end
      apply();
      while (pend != '0) begin
        re = (budget > 0) && ($urandom_range(0, 2) == 0);
        if (re) budget--;
        serve_one(int'($urandom_range(0, 3)), re);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_sched_arbiter.md
Name: mul_sched_arbiter

Overview:
- Shares one iterative 24x24 multiply + popcount engine between NUM_REQ requesters, e.g. the bus register file and the GPIO-side command path.
- Round-robin arbitration and valid/ready handshakes on both request and response sides.
- Sequences the engine through multiply, popcount and response phases.
- Publishes a completed-operation counter for the gpio_out mirror.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- A_W, 24, operand width.
- RES_W, 32, returned result width (low bits of the 48-bit product).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- req_a1  in  NUM_REQ*A_W  packed first operands; requester i at [i*A_W +: A_W].
- req_a2  in  NUM_REQ*A_W  packed second operands.
- resp_valid  out  NUM_REQ  one-hot result-available.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_result  out  RES_W  product[31:0].
- resp_ones  out  6  popcount of product[31:0] (0..32).
- resp_ovf  out  1  product[47:32] != 0.
- busy  out  1  high whenever state != IDLE.
- op_count  out  16  completed responses, wraps.

Behaviour:
- Reset: every output 0; state IDLE; rr_ptr = 0; internal product, multiplier shift register and bit counter cleared.
- Reset mid-operation: the operation is abandoned. No resp_valid is ever issued for it, and op_count is not incremented.
- States:
  - IDLE: if any req_valid, go to MULT.
  - MULT: one multiplier bit per cycle; after 24 cycles go to COUNT.
  - COUNT: one cycle to latch the popcount and overflow flag; go to RESP.
  - RESP: hold outputs until resp_ready[g]; then go to IDLE.
- Arbitration, IDLE only:
  - Search starts at rr_ptr and proceeds upward modulo NUM_REQ.
  - First requester with req_valid wins as g.
  - req_ready[g] = 1 combinationally in that cycle only; req_ready is 0 in all other states.
  - On acceptance: operands[g] latched, rr_ptr <= (g+1) mod NUM_REQ.
- Requester rule: once req_valid is asserted it stays high with stable operands until accepted. The bench checks this with an assertion.
- Latency: accept on the edge ending cycle T:
  - MULT covers T+1..T+24.
  - COUNT is T+25.
  - resp_valid[g] rises at T+26.
- MULT arithmetic: in each cycle, if a2_sh[0], then product += a1_ext << bitcnt. a2_sh is shifted right, and product is a 48-bit unsigned accumulator (no truncation inside).
- RESP outputs:
  - resp_result, resp_ones and resp_ovf are stable while resp_valid is high.
  - All three are driven 0 when no resp_valid is high.
- Response handshake:
  - The handshake completes when resp_valid[g] & resp_ready[g] are both high.
  - op_count increments on that same edge; 0xFFFF wraps to 0x0000.
- Back-to-back: the earliest next acceptance is the cycle after the handshake, when the state is IDLE again. Minimum period is 27 cycles.
- Requests arriving while busy wait; there is no queue beyond the requester's own hold.
- A2 = 0 still takes the full 24 MULT cycles unless the optional feature is compiled in.

Optional Feature:
- Macro: MUL_SCHED_EARLY_TERM_EN.
- Defined: MULT exits to COUNT on the cycle after a2_sh becomes 0. Latency = 2 + (index of highest set bit of A2 + 1) + 1. For A2 = 0, MULT lasts 1 cycle and resp_valid rises at T+3.
- Undefined: fixed 24-cycle MULT as specified above.
- Results are identical either way.

Decomposition:
- Package mul_sched_pkg:
  - state enum {IDLE, MULT, COUNT, RESP}.
  - localparams A_W_DEF = 24, PROD_W = 48, RES_W_DEF = 32, ONES_W = 6, CNT_W = 16.
  - Popcount function over 32 bits.
- Sub-module shift_add_mul24 holds the 48-bit accumulator, the a2 shift register and the bit counter.
  - Inputs: start, a1, a2.
  - Outputs: done, product.
- The arbiter/FSM top instantiates one shift_add_mul24.

Test Plan:
- Req0 A1=0x000003, A2=0x000005, resp_ready held 1 -> resp_valid[0] at T+26, resp_result=0x0000000F, resp_ones=4, resp_ovf=0, op_count=1.
- Req1 A1=A2=0xFFFFFF -> resp_result=0xFE000001, resp_ones=8, resp_ovf=1, resp_valid[1] only.
- Both req_valid high from reset, each reissuing after its response -> grants 0,1,0,1. Each req_ready pulse lasts one cycle; no grant while busy.
- resp_ready[0] held low 10 cycles in RESP -> outputs stable, busy=1, req1 not granted until the cycle after the handshake.
- Assert reset at T+12 mid-MULT -> next cycle all outputs 0. No response for the abandoned op; op_count unchanged; subsequent request completes normally.
- Preload 65535 completions (or force the counter) then one more op -> op_count=0x0000. With MUL_SCHED_EARLY_TERM_EN, A2=0x000001 -> resp_valid at T+4.
